// File: rtl/rv32m_master.sv
// rv32m_master: single-operation initiator for the rv32m multiply/divide unit.
// Accepts one request, pulses m_in_valid once, waits with a timeout, returns rd/error.
module rv32m_master #(
    parameter int unsigned N       = 32,
    parameter int unsigned TIMEOUT = 64,
    parameter int unsigned CW      = 7
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         req_valid,
    output logic         req_ready,
    input  logic [N-1:0] req_rs1,
    input  logic [N-1:0] req_rs2,
    input  logic [2:0]   req_funct3,
    output logic         rsp_valid,
    input  logic         rsp_ready,
    output logic [N-1:0] rsp_rd,
    output logic         rsp_error,
    output logic         rsp_timeout,
    output logic [15:0]  done_cnt,
    output logic [N-1:0] m_rs1,
    output logic [N-1:0] m_rs2,
    output logic [2:0]   m_funct3,
    output logic         m_in_valid,
    input  logic [N-1:0] m_rd,
    input  logic         m_out_valid,
    input  logic         m_in_error
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_DONE
    } state_e;

    localparam logic [CW-1:0] TMAX = CW'(TIMEOUT - 1);

    state_e        state_q;
    logic [CW-1:0] timer_q, timer_d;
    logic [15:0]   done_cnt_q, done_cnt_d;
    logic          req_ready_q;
    logic          rsp_valid_q;
    logic [N-1:0]  rsp_rd_q;
    logic          rsp_error_q;
    logic          rsp_timeout_q;
    logic [N-1:0]  m_rs1_q, m_rs2_q;
    logic [2:0]    m_funct3_q;
    logic          m_in_valid_q;

    always_comb begin
        timer_d    = timer_q + 1'b1;
        done_cnt_d = done_cnt_q + 16'd1;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q       <= S_IDLE;
            timer_q       <= '0;
            done_cnt_q    <= '0;
            req_ready_q   <= 1'b1;
            rsp_valid_q   <= 1'b0;
            rsp_rd_q      <= '0;
            rsp_error_q   <= 1'b0;
            rsp_timeout_q <= 1'b0;
            m_rs1_q       <= '0;
            m_rs2_q       <= '0;
            m_funct3_q    <= '0;
            m_in_valid_q  <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (req_valid && req_ready_q) begin
                        m_rs1_q      <= req_rs1;
                        m_rs2_q      <= req_rs2;
                        m_funct3_q   <= req_funct3;
                        m_in_valid_q <= 1'b1;
                        req_ready_q  <= 1'b0;
                        state_q      <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    m_in_valid_q <= 1'b0;
                    timer_q      <= '0;
                    state_q      <= S_WAIT;
                end
                S_WAIT: begin
                    timer_q <= timer_d;
                    // first WAIT cycle ignores out_valid: it may still be the previous op's level
                    if ((timer_q != '0) && m_out_valid) begin
                        rsp_rd_q      <= m_rd;
                        rsp_error_q   <= m_in_error;
                        rsp_timeout_q <= 1'b0;
                        rsp_valid_q   <= 1'b1;
                        state_q       <= S_DONE;
                    end else if (timer_q == TMAX) begin
                        rsp_rd_q      <= '0;
                        rsp_error_q   <= 1'b0;
                        rsp_timeout_q <= 1'b1;
                        rsp_valid_q   <= 1'b1;
                        state_q       <= S_DONE;
                    end
                end
                S_DONE: begin
                    if (rsp_ready) begin
                        rsp_valid_q <= 1'b0;
                        req_ready_q <= 1'b1;
                        done_cnt_q  <= done_cnt_d;
                        state_q     <= S_IDLE;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign req_ready   = req_ready_q;
    assign rsp_valid   = rsp_valid_q;
    assign rsp_rd      = rsp_rd_q;
    assign rsp_error   = rsp_error_q;
    assign rsp_timeout = rsp_timeout_q;
    assign done_cnt    = done_cnt_q;
    assign m_rs1       = m_rs1_q;
    assign m_rs2       = m_rs2_q;
    assign m_funct3    = m_funct3_q;
    assign m_in_valid  = m_in_valid_q;

endmodule
